// File: rtl/accum_frame_ctrl.sv
// -----------------------------------------------------------------------------
// accum_frame_ctrl
//
// Frame sequencer for the signed accumulator datapath. A frame starts with
// start_i, which latches the frame length. The controller then clears the
// accumulator and streams exactly that many samples into it over a valid/ready
// port. It waits one cycle for the accumulator register to settle, then
// presents the sum and a sticky overflow flag on an output valid/ready port.
//
// Ports
//   clk, rst_i              clock (rising edge), asynchronous active-high reset
//   start_i, frame_len_i    frame start and length; sampled only while idle
//   abort_i                 abandon the current frame and return to idle
//   busy_o                  high whenever a frame is in progress
//   s_valid_i/s_ready_o/s_data_i    sample input stream
//   acc_en_o/acc_clear_o/acc_data_o control and data to the accumulator
//   acc_result_i            accumulator result, registered (1-cycle latency)
//   m_valid_o/m_ready_i/m_data_o/m_ovf_o result output stream
// -----------------------------------------------------------------------------
module accum_frame_ctrl #(
  parameter int DIN_WIDTH  = 32,
  parameter int DOUT_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  frame_len_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DIN_WIDTH-1:0]  s_data_i,
  output logic                  acc_en_o,
  output logic                  acc_clear_o,
  output logic [DIN_WIDTH-1:0]  acc_data_o,
  input  logic [DOUT_WIDTH-1:0] acc_result_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DOUT_WIDTH-1:0] m_data_o,
  output logic                  m_ovf_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ACCUM = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  // Signed-add overflow: operands share a sign and the wrapped sum does not.
  function automatic logic add_ovf(input logic [DOUT_WIDTH-1:0] a,
                                   input logic [DOUT_WIDTH-1:0] b);
    logic [DOUT_WIDTH-1:0] s;
    s = a + b;
    return (a[DOUT_WIDTH-1] == b[DOUT_WIDTH-1]) && (s[DOUT_WIDTH-1] != a[DOUT_WIDTH-1]);
  endfunction

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_count;
  logic                  r_ovf;
  logic [DOUT_WIDTH-1:0] r_m_data;

  logic                  w_in_accum;
  logic                  w_last;
  logic                  w_hs;
  logic                  w_acc_clear;
  logic [DOUT_WIDTH-1:0] w_sample_ext;

  assign w_in_accum   = (r_state == ST_ACCUM);
  // r_len is at least 1 whenever ACCUM is entered, so len-1 never underflows.
  assign w_last       = (r_count == (r_len - LEN_WIDTH'(1'b1)));
  assign w_sample_ext = DOUT_WIDTH'($signed(s_data_i));

  // State register.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; abort overrides everything, including a pending handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_clear = 1'b0;
    w_hs        = 1'b0;
    if (abort_i && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
      w_acc_clear = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            w_state_nxt = ST_CLEAR;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_CLEAR: begin
          w_acc_clear = 1'b1;
          if (r_len == {LEN_WIDTH{1'b0}}) begin
            w_state_nxt = ST_DRAIN;
          end else begin
            w_state_nxt = ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          w_hs = s_valid_i;
          if (s_valid_i && w_last) begin
            w_state_nxt = ST_DRAIN;
          end else begin
            w_state_nxt = ST_ACCUM;
          end
        end
        ST_DRAIN: begin
          w_state_nxt = ST_HOLD;
        end
        ST_HOLD: begin
          if (m_ready_i) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_HOLD;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Frame length is captured only when a frame is accepted from idle.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_len <= {LEN_WIDTH{1'b0}};
    end else if ((r_state == ST_IDLE) && start_i) begin
      r_len <= frame_len_i;
    end
  end

  // Accepted-sample counter, restarted by every CLEAR.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_count <= {LEN_WIDTH{1'b0}};
    end else if (r_state == ST_CLEAR) begin
      r_count <= {LEN_WIDTH{1'b0}};
    end else if (w_hs) begin
      r_count <= r_count + LEN_WIDTH'(1'b1);
    end
  end

  // Sticky overflow; acc_result_i already holds the sum of all earlier samples
  // at each handshake, so it is the correct left operand.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_ovf <= 1'b0;
    end else if (r_state == ST_CLEAR) begin
      r_ovf <= 1'b0;
    end else if (w_hs && add_ovf(acc_result_i, w_sample_ext)) begin
      r_ovf <= 1'b1;
    end
  end

  // Result capture in DRAIN, when the accumulator has absorbed the last sample.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_m_data <= {DOUT_WIDTH{1'b0}};
    end else if (r_state == ST_DRAIN) begin
      r_m_data <= acc_result_i;
    end
  end

  assign busy_o      = (r_state != ST_IDLE);
  assign s_ready_o   = w_in_accum;
  assign acc_en_o    = w_hs;
  assign acc_clear_o = w_acc_clear;
  assign acc_data_o  = w_in_accum ? s_data_i : {DIN_WIDTH{1'b0}};
  assign m_valid_o   = (r_state == ST_HOLD);
  assign m_data_o    = r_m_data;
  assign m_ovf_o     = r_ovf;

endmodule

// File: tb/tb_accum_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_accum_frame_ctrl
//
// Self-checking bench for accum_frame_ctrl. A simple registered accumulator
// stands in for the real datapath. The expected frame sum and overflow flag are
// computed from the accepted samples with exact 64-bit arithmetic, then wrapped.
// -----------------------------------------------------------------------------
module tb_accum_frame_ctrl;
  localparam int DW = 32;
  localparam int OW = 32;
  localparam int LW = 16;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] frame_len;
  logic          abort;
  logic          busy;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          acc_en;
  logic          acc_clear;
  logic [DW-1:0] acc_data;
  logic [OW-1:0] acc_r = '0;
  logic          m_valid;
  logic          m_ready;
  logic [OW-1:0] m_data;
  logic          m_ovf;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_cnt = 0;
  int dq[$];
  bit vq[$];

  accum_frame_ctrl #(.DIN_WIDTH(DW), .DOUT_WIDTH(OW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_i(rst), .start_i(start), .frame_len_i(frame_len),
    .abort_i(abort), .busy_o(busy), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .s_data_i(s_data), .acc_en_o(acc_en), .acc_clear_o(acc_clear),
    .acc_data_o(acc_data), .acc_result_i(acc_r), .m_valid_o(m_valid),
    .m_ready_i(m_ready), .m_data_o(m_data), .m_ovf_o(m_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Stand-in accumulator: registered, not touched by rst.
  always @(posedge clk) begin
    if (acc_clear) acc_r <= '0;
    else if (acc_en) acc_r <= acc_r + OW'($signed(acc_data));
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int rand_sample();
    case ($urandom_range(3))
      0: return int'($urandom());
      1: return int'(32'h7FFF_FF00 + 32'($urandom_range(255)));
      2: return int'(32'h8000_0000 + 32'($urandom_range(255)));
      default: return int'($urandom_range(2000)) - 1000;
    endcase
  endfunction

  // One frame: start, stream len samples (abort at sample index abort_at if
  // >= 0), then hold the result for hold_wait cycles before accepting it.
  task automatic run_frame(input int len, input int stall_pct, input int hold_wait,
                           input int abort_at, input bit abort_hold);
    logic [31:0] sum_w;
    bit          ovf_x;
    int          sent;
    int          cyc;
    int          t_last;
    int          d;
    bit          v;
    longint      exact;
    sum_w = '0; ovf_x = 1'b0; sent = 0; cyc = 0;
    start = 1'b1; frame_len = LW'(len);
    step();
    start = 1'b0; frame_len = '0;
    check_val("clear_pulse", 32'(acc_clear), 32'd1);
    check_val("clear_busy", 32'(busy), 32'd1);
    check_val("clear_ready", 32'(s_ready), 32'd0);
    check_val("clear_en", 32'(acc_en), 32'd0);
    t_last = cyc_cnt;
    step();
    while (sent < len) begin
      if (cyc >= 400) begin
        check_val("accum_timeout", 32'(cyc), 32'd0);
        break;
      end
      if (vq.size() > 0) v = vq.pop_front();
      else v = ($urandom_range(99) >= stall_pct);
      if (v && dq.size() > 0) d = dq.pop_front();
      else d = rand_sample();
      s_valid = v; s_data = 32'(d); abort = (sent == abort_at);
      #1;
      check_val("acc_ready", 32'(s_ready), 32'd1);
      check_val("acc_en", 32'(acc_en), 32'(v && !abort));
      check_val("acc_clear", 32'(acc_clear), 32'(abort));
      check_val("acc_data", acc_data, 32'(d));
      if (abort) begin
        step();
        abort = 1'b0; s_valid = 1'b0;
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_mvalid", 32'(m_valid), 32'd0);
        check_val("abort_clear_drop", 32'(acc_clear), 32'd0);
        step();
        check_val("abort_mvalid2", 32'(m_valid), 32'd0);
        return;
      end
      if (v) begin
        exact = longint'($signed(sum_w)) + longint'(d);
        if (exact > MAXV || exact < MINV) ovf_x = 1'b1;
        sum_w = sum_w + 32'(d);
        sent++;
        t_last = cyc_cnt;
      end
      step();
      cyc++;
    end
    s_valid = 1'b0; abort = 1'b0;
    check_val("drain_mvalid", 32'(m_valid), 32'd0);
    check_val("drain_busy", 32'(busy), 32'd1);
    check_val("drain_ready", 32'(s_ready), 32'd0);
    step();
    if (abort_hold) begin
      abort = 1'b1;
      #1;
      check_val("hold_abort_clear", 32'(acc_clear), 32'd1);
      step();
      abort = 1'b0;
      check_val("hold_abort_busy", 32'(busy), 32'd0);
      check_val("hold_abort_mvalid", 32'(m_valid), 32'd0);
      return;
    end
    check_val("hold_mvalid", 32'(m_valid), 32'd1);
    check_val("latency", 32'(cyc_cnt), 32'(t_last + 2));
    check_val("hold_data", m_data, sum_w);
    check_val("hold_ovf", 32'(m_ovf), 32'(ovf_x));
    for (int i = 0; i < hold_wait; i++) begin
      m_ready = 1'b0;
      start = (i == 0);
      step();
      start = 1'b0;
      check_val("stall_mvalid", 32'(m_valid), 32'd1);
      check_val("stall_data", m_data, sum_w);
      check_val("stall_ovf", 32'(m_ovf), 32'(ovf_x));
      check_val("stall_busy", 32'(busy), 32'd1);
    end
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check_val("done_mvalid", 32'(m_valid), 32'd0);
    check_val("done_busy", 32'(busy), 32'd0);
  endtask

  // Asynchronous reset in the middle of ACCUM.
  task automatic reset_mid_accum();
    start = 1'b1; frame_len = 16'd8;
    step();
    start = 1'b0;
    step();
    s_valid = 1'b1; s_data = 32'd9;
    #1;
    check_val("pre_rst_en", 32'(acc_en), 32'd1);
    step();
    #2;
    rst = 1'b1;
    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_ready", 32'(s_ready), 32'd0);
    check_val("rst_en", 32'(acc_en), 32'd0);
    check_val("rst_clear", 32'(acc_clear), 32'd0);
    check_val("rst_acc_data", acc_data, 32'd0);
    check_val("rst_mvalid", 32'(m_valid), 32'd0);
    check_val("rst_mdata", m_data, 32'd0);
    check_val("rst_ovf", 32'(m_ovf), 32'd0);
    s_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    int rl, rs, rh, ra;
    bit rb;
    rst = 1'b1; start = 1'b0; frame_len = '0; abort = 1'b0;
    s_valid = 1'b1; s_data = 32'hA5A5_A5A5; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_busy", 32'(busy), 32'd0);
    check_val("reset_ready", 32'(s_ready), 32'd0);
    check_val("reset_en", 32'(acc_en), 32'd0);
    check_val("reset_clear", 32'(acc_clear), 32'd0);
    check_val("reset_acc_data", acc_data, 32'd0);
    check_val("reset_mvalid", 32'(m_valid), 32'd0);
    check_val("reset_mdata", m_data, 32'd0);
    check_val("reset_ovf", 32'(m_ovf), 32'd0);
    s_valid = 1'b0;
    rst = 1'b0;
    step();

    dq = '{1, 2, 3, 4}; vq = '{1, 1, 1, 1};
    run_frame(4, 0, 0, -1, 1'b0);
    dq = '{5, -7, 2}; vq = '{1, 0, 1, 0, 1};
    run_frame(3, 0, 5, -1, 1'b0);
    dq = '{32'h7FFF_FFFF, 1};
    run_frame(2, 0, 1, -1, 1'b0);
    dq = '{1};
    run_frame(1, 0, 0, -1, 1'b0);
    run_frame(0, 0, 2, -1, 1'b0);
    dq = '{11, 22};
    run_frame(5, 0, 0, 1, 1'b0);
    run_frame(3, 0, 0, -1, 1'b0);
    dq = '{32'h7FFF_FFFF, 5};
    run_frame(2, 0, 0, -1, 1'b0);
    reset_mid_accum();
    run_frame(4, 20, 1, -1, 1'b0);
    run_frame(2, 0, 0, -1, 1'b1);
    run_frame(2, 0, 0, -1, 1'b0);

    for (int k = 0; k < 60; k++) begin
      rl = int'($urandom_range(12));
      rs = int'($urandom_range(60));
      rh = int'($urandom_range(3));
      if ($urandom_range(7) == 0) ra = int'($urandom_range(4));
      else ra = -1;
      rb = ($urandom_range(9) == 0);
      run_frame(rl, rs, rh, ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
